// File: rtl/gamma_loader_if.sv
// Control, byte-stream and LUT-write signals between the gamma loader and its host/LUT.
interface gamma_loader_if;
    logic       load_start;
    logic       linear_req;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       enable_req;
    logic       gamma_wr;
    logic [9:0] gamma_wr_addr;
    logic [7:0] gamma_value;
    logic       gamma_en;
    logic       busy;
    logic       done;
    logic       err;

    modport master (
        output load_start, linear_req, in_valid, in_data, enable_req,
        input  in_ready, gamma_wr, gamma_wr_addr, gamma_value, gamma_en, busy, done, err
    );

    modport slave (
        input  load_start, linear_req, in_valid, in_data, enable_req,
        output in_ready, gamma_wr, gamma_wr_addr, gamma_value, gamma_en, busy, done, err
    );
endinterface

// File: rtl/gamma_loader.sv
// Fills the gamma LUT from a byte stream or an identity curve; accepted byte -> LUT write one cycle later.
// in_ready is high for the whole LOAD state except in an abort cycle; gamma_en is held off until a full curve lands.
module gamma_loader #(
    parameter int CURVE_LEN   = 768,
    parameter bit AUTO_LINEAR = 1'b1
) (
    input  logic          clk_sys,
    input  logic          reset,
    gamma_loader_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_LINEAR, S_LOAD} state_t;

    localparam logic [9:0] LAST = 10'(CURVE_LEN - 1);

    state_t     r_state;
    logic [9:0] r_cnt;
    logic       r_curve_valid;
    logic       r_auto_pend;
    logic       r_gamma_wr;
    logic [9:0] r_addr;
    logic [7:0] r_value;
    logic       r_gamma_en;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       w_go;

    // A fill starting this cycle must already keep gamma_en low alongside the rising busy.
    assign w_go = (r_state == S_IDLE) & (bus.load_start | bus.linear_req | r_auto_pend);

    assign bus.in_ready      = (r_state == S_LOAD) & ~bus.load_start;
    assign bus.gamma_wr      = r_gamma_wr;
    assign bus.gamma_wr_addr = r_addr;
    assign bus.gamma_value   = r_value;
    assign bus.gamma_en      = r_gamma_en;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.err           = r_err;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_curve_valid <= 1'b0;
            r_auto_pend   <= AUTO_LINEAR;
            r_gamma_wr    <= 1'b0;
            r_addr        <= '0;
            r_value       <= '0;
            r_gamma_en    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_gamma_wr  <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_auto_pend <= 1'b0;
            r_gamma_en  <= bus.enable_req & r_curve_valid & ~r_busy & ~w_go;

            case (r_state)
                S_IDLE: begin
                    if (bus.load_start) begin
                        r_state       <= S_LOAD;
                        r_cnt         <= '0;
                        r_curve_valid <= 1'b0;
                        r_busy        <= 1'b1;
                    end else if (bus.linear_req | r_auto_pend) begin
                        r_state       <= S_LINEAR;
                        r_cnt         <= '0;
                        r_curve_valid <= 1'b0;
                        r_busy        <= 1'b1;
                    end
                end

                S_LINEAR: begin
                    if (bus.load_start) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                    end else begin
                        r_gamma_wr <= 1'b1;
                        r_addr     <= r_cnt;
                        r_value    <= r_cnt[7:0];
                        if (r_cnt == LAST) begin
                            r_state       <= S_IDLE;
                            r_curve_valid <= 1'b1;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 10'd1;
                        end
                    end
                end

                S_LOAD: begin
                    // A restart discards the partial curve; the byte offered this cycle is refused.
                    if (bus.load_start) begin
                        r_err <= 1'b1;
                        r_cnt <= '0;
                    end else if (bus.in_valid) begin
                        r_gamma_wr <= 1'b1;
                        r_addr     <= r_cnt;
                        r_value    <= bus.in_data;
                        if (r_cnt == LAST) begin
                            r_state       <= S_IDLE;
                            r_curve_valid <= 1'b1;
                            r_done        <= 1'b1;
                            r_busy        <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 10'd1;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
